mesi_coherence_controller: RTL and testbench
============================================

Name: mesi_coherence_controller

Overview:
- Per-cache snoopy invalidate-protocol controller: next generation of the combinational MSI table.
- Holds the tag and coherence state of every line, and sequences CPU misses and upgrades onto the shared bus through a request/grant handshake.
- Services snoops concurrently with CPU activity.
- Parametrised in geometry; MESI or MSI operating mode. The data array and RAM datapath sit outside the block and are driven by its command outputs.

Parameters:
- INDEX_WIDTH, 4, log2 of line count (16 lines).
- TAG_WIDTH, 8, tag bits; address width ADDR_W = TAG_WIDTH+INDEX_WIDTH.
- ENABLE_EXCLUSIVE, 1, 1 = MESI, 0 = MSI (EXCLUSIVE never entered).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- cpuRead  in  1  CPU read request, held until cpuDone.
- cpuWrite  in  1  CPU write request, held until cpuDone; never together with cpuRead.
- cpuAddress  in  ADDR_W  request address, {tag,index}.
- cpuDone  out  1  one-cycle pulse: access complete, line held with required permission.
- writeBackRequest  out  1  victim write-back to RAM, held until writeBackDone.
- writeBackAddress  out  ADDR_W  victim address.
- writeBackDone  in  1  write-back complete.
- busRequest  out  1  bus arbitration request.
- busGrant  in  1  bus granted.
- busCommand  out  2  0 NONE, 1 BUS_READ, 2 BUS_READ_EXCLUSIVE, 3 BUS_INVALIDATE.
- busAddress  out  ADDR_W  transaction address.
- busSharedIn  in  1  another cache holds the line; sampled on busDone.
- busDone  in  1  bus transaction complete.
- snoopValid  in  1  foreign bus transaction visible. The bus never presents this cache's own transaction.
- snoopCommand  in  2  encoding as busCommand.
- snoopAddress  in  ADDR_W  snooped address.
- snoopSharedOut  out  1  registered; snoop hit on a valid line, one cycle after snoopValid.
- snoopFlush  out  1  registered one-cycle pulse; a MODIFIED line was snooped and must be flushed.

Behaviour:
- State encoding: INVALID=0, SHARED=1, EXCLUSIVE=2, MODIFIED=3.
- Hit: state≠INVALID and the stored tag matches.
- On reset: all lines INVALID, FSM IDLE, every output 0. Reset mid-transaction abandons it with no bus or RAM side effects.
- FSM states: IDLE, WRITE_BACK, WAIT_GRANT, BUS_ACTIVE, DONE.
- IDLE, read hit: cpuDone the next cycle (latency 1); line state unchanged.
- IDLE, write hit on E or M: line becomes M; cpuDone the next cycle. No bus traffic.
- IDLE, write hit on S: pending command = INVALIDATE; go to WAIT_GRANT.
- IDLE, miss: pending command = READ (for cpuRead) or READ_EXCLUSIVE (for cpuWrite).
  - Victim M: go to WRITE_BACK.
  - Otherwise: go to WAIT_GRANT.
- WRITE_BACK: writeBackRequest=1 with the victim address. On writeBackDone, the victim becomes INVALID and the FSM goes to WAIT_GRANT.
- WAIT_GRANT: busRequest=1 until busGrant is seen, then go to BUS_ACTIVE.
- BUS_ACTIVE: drive busCommand/busAddress until busDone, keeping busRequest=1. On busDone, write the tag and set the state:
  - READ: E if ENABLE_EXCLUSIVE and !busSharedIn, else S.
  - READ_EXCLUSIVE or INVALIDATE: M.
  - Then go to DONE.
- DONE: cpuDone=1 for one cycle, then IDLE. busCommand is NONE outside BUS_ACTIVE.
- Snoop handling, every cycle when snoopValid and hit, regardless of FSM state:
  - BUS_READ: M→S with snoopFlush; E→S; S stays S.
  - BUS_READ_EXCLUSIVE: M→I with snoopFlush; E/S→I.
  - BUS_INVALIDATE: →I.
  - snoopSharedOut=1 on any hit.
  - Snoop miss or NONE: no change.
- Upgrade race: if a snoop invalidates the target line while the pending command is INVALIDATE and the FSM is in WAIT_GRANT, the pending command becomes READ_EXCLUSIVE before the grant.
- Same-index conflict in IDLE: when snoopValid and the snoop index equals the CPU index in the same cycle, the snoop takes priority. The CPU request is not evaluated that cycle; it is re-evaluated the next cycle against the updated state.
- Snoop hitting the victim during WRITE_BACK: the state update and snoopFlush apply, and the write-back still completes.
- Snoop hitting the line under fill in BUS_ACTIVE: ignored, because the bus serialises transactions.
- With ENABLE_EXCLUSIVE=0, the EXCLUSIVE encoding is unreachable.

Test Plan:
- Reset, then cpuRead 0x1A3 with busSharedIn=0 → busRequest, then after grant busCommand=1, busAddress=0x1A3; on busDone, line 3 becomes E; cpuDone pulses 1 cycle later.
- Repeat with ENABLE_EXCLUSIVE=0 → line 3 becomes S; then cpuWrite 0x1A3 → busCommand=3, line 3 becomes M, cpuDone.
- Line 5 M (tag 0x2B), cpuRead 0x3C5 → writeBackRequest with writeBackAddress=0x2B5 until writeBackDone, then BUS_READ 0x3C5; final state S or E per busSharedIn.
- Line 7 M; snoop BUS_READ 0x107 → next cycle snoopSharedOut=1 and snoopFlush=1; line 7 becomes S; snoop READ_EXCLUSIVE 0x107 → line 7 becomes I, snoopFlush=0.
- Line 2 S, cpuWrite 0x102 while busGrant=0, then snoop BUS_INVALIDATE 0x102 → after grant busCommand=2 (not 3); line 2 ends M.
- Assert reset during BUS_ACTIVE → all outputs 0 immediately; subsequent cpuRead of a previously valid address misses.

Source files
------------

// File: rtl/mesi_coherence_controller.sv
// ---------------------------------------------------------------------------
// mesi_coherence_controller
//   Snoopy invalidate-protocol controller for one direct-mapped cache.
//   Keeps tag + coherence state per line, sequences CPU misses/upgrades onto
//   the shared bus (request/grant), and services foreign snoops every cycle.
//   ENABLE_EXCLUSIVE=0 degrades to MSI (EXCLUSIVE is never written).
//
// Ports
//   clock, reset          rising-edge clock, async active-low reset
//   cpuRead/cpuWrite      CPU request, held until cpuDone
//   cpuAddress            {tag,index}
//   cpuDone               1-cycle completion pulse
//   writeBackRequest/Address/Done   victim write-back handshake to RAM
//   busRequest/busGrant   bus arbitration
//   busCommand/busAddress transaction driven while the bus is owned
//   busSharedIn/busDone   fill response (sharedIn sampled on busDone)
//   snoopValid/Command/Address      foreign bus transaction
//   snoopSharedOut        registered: snoop hit on a valid line
//   snoopFlush            registered pulse: snooped line was MODIFIED
// ---------------------------------------------------------------------------
module mesi_coherence_controller #(
    parameter int INDEX_WIDTH      = 4,
    parameter int TAG_WIDTH        = 8,
    parameter int ENABLE_EXCLUSIVE = 1,
    localparam int ADDR_W          = TAG_WIDTH + INDEX_WIDTH
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cpuRead,
    input  logic              cpuWrite,
    input  logic [ADDR_W-1:0] cpuAddress,
    output logic              cpuDone,
    output logic              writeBackRequest,
    output logic [ADDR_W-1:0] writeBackAddress,
    input  logic              writeBackDone,
    output logic              busRequest,
    input  logic              busGrant,
    output logic [1:0]        busCommand,
    output logic [ADDR_W-1:0] busAddress,
    input  logic              busSharedIn,
    input  logic              busDone,
    input  logic              snoopValid,
    input  logic [1:0]        snoopCommand,
    input  logic [ADDR_W-1:0] snoopAddress,
    output logic              snoopSharedOut,
    output logic              snoopFlush
);

    localparam int LINES = 1 << INDEX_WIDTH;

    typedef enum logic [1:0] {
        INVALID   = 2'd0,
        SHARED    = 2'd1,
        EXCLUSIVE = 2'd2,
        MODIFIED  = 2'd3
    } lineState_t;

    typedef enum logic [2:0] {
        IDLE, WRITE_BACK, WAIT_GRANT, BUS_ACTIVE, DONE
    } fsmState_t;

    localparam logic [1:0] CMD_NONE    = 2'd0;
    localparam logic [1:0] CMD_READ    = 2'd1;
    localparam logic [1:0] CMD_READ_EX = 2'd2;
    localparam logic [1:0] CMD_INV     = 2'd3;

    lineState_t             lineState [LINES];
    logic [TAG_WIDTH-1:0]   lineTag   [LINES];

    fsmState_t              state, nextState;
    logic [ADDR_W-1:0]      reqAddr, victimAddr;
    logic [1:0]             pendCmd;

    logic [INDEX_WIDTH-1:0] cpuIdx, snpIdx, reqIdx;
    logic [TAG_WIDTH-1:0]   cpuTag, snpTag, reqTag;
    lineState_t             cpuLine, snpLine;
    logic                   cpuHit;

    logic                   snoopHit, raceKill;
    lineState_t             snoopNext;

    // FSM-side line updates (decoded in the next-state process)
    logic                   capture, lineWrEn, fillEn;
    logic [INDEX_WIDTH-1:0] lineWrIdx;
    lineState_t             lineWrState;
    logic [1:0]             capCmd;

    assign cpuIdx  = cpuAddress[INDEX_WIDTH-1:0];
    assign cpuTag  = cpuAddress[ADDR_W-1:INDEX_WIDTH];
    assign snpIdx  = snoopAddress[INDEX_WIDTH-1:0];
    assign snpTag  = snoopAddress[ADDR_W-1:INDEX_WIDTH];
    assign reqIdx  = reqAddr[INDEX_WIDTH-1:0];
    assign reqTag  = reqAddr[ADDR_W-1:INDEX_WIDTH];

    assign cpuLine = lineState[cpuIdx];
    assign snpLine = lineState[snpIdx];
    assign cpuHit  = (cpuLine != INVALID) && (lineTag[cpuIdx] == cpuTag);

    // The line being filled is owned by our in-flight transaction; the bus
    // orders it after ours, so a snoop on that index is dropped.
    assign snoopHit = snoopValid && (snoopCommand != CMD_NONE) &&
                      (snpLine != INVALID) && (lineTag[snpIdx] == snpTag) &&
                      !((state == BUS_ACTIVE) && (snpIdx == reqIdx));

    assign snoopNext = (snoopCommand == CMD_READ) ? SHARED : INVALID;

    // Our S copy was taken away while waiting for the bus: an invalidate
    // would leave us with no data, so fetch the line exclusively instead.
    assign raceKill = (state == WAIT_GRANT) && (pendCmd == CMD_INV) &&
                      snoopHit && (snpIdx == reqIdx) && (snpTag == reqTag) &&
                      (snoopCommand != CMD_READ);

    always_comb begin
        nextState   = state;
        capture     = 1'b0;
        capCmd      = CMD_NONE;
        lineWrEn    = 1'b0;
        lineWrIdx   = reqIdx;
        lineWrState = INVALID;
        fillEn      = 1'b0;
        case (state)
            IDLE: begin
                // A same-index snoop wins the cycle; CPU retries next cycle.
                if ((cpuRead || cpuWrite) && !(snoopValid && (snpIdx == cpuIdx))) begin
                    capture = 1'b1;
                    if (cpuHit) begin
                        if (cpuRead) begin
                            nextState = DONE;
                        end else if (cpuLine != SHARED) begin
                            lineWrEn    = 1'b1;
                            lineWrIdx   = cpuIdx;
                            lineWrState = MODIFIED;
                            nextState   = DONE;
                        end else begin
                            capCmd    = CMD_INV;
                            nextState = WAIT_GRANT;
                        end
                    end else begin
                        capCmd    = cpuWrite ? CMD_READ_EX : CMD_READ;
                        nextState = (cpuLine == MODIFIED) ? WRITE_BACK : WAIT_GRANT;
                    end
                end
            end
            WRITE_BACK: begin
                if (writeBackDone) begin
                    lineWrEn    = 1'b1;
                    lineWrState = INVALID;
                    nextState   = WAIT_GRANT;
                end
            end
            WAIT_GRANT: begin
                if (busGrant) nextState = BUS_ACTIVE;
            end
            BUS_ACTIVE: begin
                if (busDone) begin
                    fillEn   = 1'b1;
                    lineWrEn = 1'b1;
                    if (pendCmd == CMD_READ)
                        lineWrState = ((ENABLE_EXCLUSIVE != 0) && !busSharedIn) ? EXCLUSIVE : SHARED;
                    else
                        lineWrState = MODIFIED;
                    nextState = DONE;
                end
            end
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            reqAddr        <= '0;
            victimAddr     <= '0;
            pendCmd        <= CMD_NONE;
            snoopSharedOut <= 1'b0;
            snoopFlush     <= 1'b0;
        end else begin
            state          <= nextState;
            snoopSharedOut <= snoopHit;
            snoopFlush     <= snoopHit && (snpLine == MODIFIED);
            if (capture) begin
                reqAddr    <= cpuAddress;
                victimAddr <= {lineTag[cpuIdx], cpuIdx};
                pendCmd    <= capCmd;
            end else if (raceKill) begin
                pendCmd    <= CMD_READ_EX;
            end
        end
    end

    // Snoop update first; an FSM write to the same line in the same cycle
    // (write-back completion) takes precedence.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < LINES; i++) lineState[i] <= INVALID;
        end else begin
            if (snoopHit) lineState[snpIdx]    <= snoopNext;
            if (lineWrEn) lineState[lineWrIdx] <= lineWrState;
        end
    end

    // Tags are only meaningful alongside a valid state, so no reset needed.
    always_ff @(posedge clock) begin
        if (fillEn) lineTag[reqIdx] <= reqTag;
    end

    assign cpuDone          = (state == DONE);
    assign writeBackRequest = (state == WRITE_BACK);
    assign writeBackAddress = (state == WRITE_BACK) ? victimAddr : '0;
    assign busRequest       = (state == WAIT_GRANT) || (state == BUS_ACTIVE);
    assign busCommand       = (state == BUS_ACTIVE) ? pendCmd : CMD_NONE;
    assign busAddress       = (state == BUS_ACTIVE) ? reqAddr : '0;

endmodule

// File: tb/tb_mesi_coherence_controller.sv
// ---------------------------------------------------------------------------
// Bench for mesi_coherence_controller. Two instances: index 0 runs MESI,
// index 1 runs MSI. A line-level reference model (state number + tag per
// line) predicts bus commands, write-back addresses, snoop responses and
// completion latency for directed and random traffic.
// ---------------------------------------------------------------------------
module tb_mesi_coherence_controller;

    logic        clock;
    logic        reset;
    logic        cpuRead[2], cpuWrite[2], writeBackDone[2], busGrant[2];
    logic        busSharedIn[2], busDone[2], snoopValid[2];
    logic [11:0] cpuAddress[2], snoopAddress[2];
    logic [1:0]  snoopCommand[2];
    logic        cpuDone[2], writeBackRequest[2], busRequest[2];
    logic        snoopSharedOut[2], snoopFlush[2];
    logic [11:0] writeBackAddress[2], busAddress[2];
    logic [1:0]  busCommand[2];

    int nVec = 0;
    int nErr = 0;

    int         mState[2][16];
    logic [7:0] mTag[2][16];
    bit         mesi[2] = '{1'b1, 1'b0};

    for (genvar g = 0; g < 2; g++) begin : gDut
        mesi_coherence_controller #(
            .INDEX_WIDTH(4), .TAG_WIDTH(8), .ENABLE_EXCLUSIVE(g == 0 ? 1 : 0)
        ) u (
            .clock(clock), .reset(reset),
            .cpuRead(cpuRead[g]), .cpuWrite(cpuWrite[g]), .cpuAddress(cpuAddress[g]),
            .cpuDone(cpuDone[g]),
            .writeBackRequest(writeBackRequest[g]), .writeBackAddress(writeBackAddress[g]),
            .writeBackDone(writeBackDone[g]),
            .busRequest(busRequest[g]), .busGrant(busGrant[g]),
            .busCommand(busCommand[g]), .busAddress(busAddress[g]),
            .busSharedIn(busSharedIn[g]), .busDone(busDone[g]),
            .snoopValid(snoopValid[g]), .snoopCommand(snoopCommand[g]),
            .snoopAddress(snoopAddress[g]),
            .snoopSharedOut(snoopSharedOut[g]), .snoopFlush(snoopFlush[g])
        );
    end

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nVec++;
        if (got !== exp) begin
            nErr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] allOuts(input int d);
        return {1'b0, cpuDone[d], writeBackRequest[d], writeBackAddress[d], busRequest[d],
                busCommand[d], busAddress[d], snoopSharedOut[d], snoopFlush[d]};
    endfunction

    task automatic clearModel();
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 16; i++) begin
                mState[d][i] = 0;
                mTag[d][i]   = '0;
            end
    endtask

    // Protocol rules for a foreign transaction: read downgrades, others kill.
    task automatic mSnoop(input int d, input int cmd, input logic [11:0] a,
                          output bit sh, output bit fl);
        int idx;
        idx = int'(a[3:0]);
        sh  = (cmd != 0) && (mState[d][idx] != 0) && (mTag[d][idx] == a[11:4]);
        fl  = sh && (mState[d][idx] == 3);
        if (sh) mState[d][idx] = (cmd == 1) ? 1 : 0;
    endtask

    task automatic snoop(input int d, input int cmd, input logic [11:0] a);
        bit sh, fl;
        mSnoop(d, cmd, a, sh, fl);
        @(negedge clock);
        snoopValid[d] = 1'b1; snoopCommand[d] = 2'(cmd); snoopAddress[d] = a;
        @(negedge clock);
        snoopValid[d] = 1'b0;
        chk("snpShared", snoopSharedOut[d], sh);
        chk("snpFlush", snoopFlush[d], fl);
    endtask

    // One CPU access, reacting as RAM/arbiter/bus. sCmd!=0 without race:
    // snoop presented in the same cycle as the request (same-index conflict).
    // race: invalidating snoop to the target while waiting for the grant.
    task automatic cpuAccess(input int d, input bit wr, input logic [11:0] a, input bit sh,
                             input int sCmd, input logic [11:0] sA, input bit race);
        int idx, expCmd, gotCmd, cyc, doneAt, grantWait, busWait, wbWait;
        bit hit, expWB, gotWB, expSh, expFl, snoopChk, raced, conflict;
        logic [11:0] expWBA;
        idx = int'(a[3:0]);
        conflict = (sCmd != 0) && !race;
        expSh = 0; expFl = 0;
        if (conflict) mSnoop(d, sCmd, sA, expSh, expFl);
        hit    = (mState[d][idx] != 0) && (mTag[d][idx] == a[11:4]);
        expWB  = !hit && (mState[d][idx] == 3);
        expWBA = {mTag[d][idx], a[3:0]};
        if (!hit) expCmd = wr ? 2 : 1;
        else if (wr && mState[d][idx] == 1) expCmd = race ? 2 : 3;
        else expCmd = 0;
        gotCmd = 0; gotWB = 0; cyc = 0; doneAt = -100; raced = 0;
        grantWait = $urandom_range(0, 2); busWait = $urandom_range(0, 2);
        wbWait = $urandom_range(0, 2);
        @(negedge clock);
        cpuRead[d] = !wr; cpuWrite[d] = wr; cpuAddress[d] = a;
        snoopChk = conflict;
        if (conflict) begin
            snoopValid[d] = 1'b1; snoopCommand[d] = 2'(sCmd); snoopAddress[d] = sA;
        end
        while (cyc < 60) begin
            @(negedge clock);
            cyc++;
            snoopValid[d] = 0; busGrant[d] = 0; busDone[d] = 0;
            writeBackDone[d] = 0; busSharedIn[d] = 0;
            if (snoopChk) begin
                chk("snpShared", snoopSharedOut[d], expSh);
                chk("snpFlush", snoopFlush[d], expFl);
                snoopChk = 0;
            end
            if (cpuDone[d]) break;
            if (writeBackRequest[d]) begin
                if (!gotWB) chk("wbAddr", writeBackAddress[d], expWBA);
                gotWB = 1;
                if (wbWait == 0) writeBackDone[d] = 1; else wbWait--;
            end
            if (busRequest[d] && busCommand[d] == 0) begin
                if (race && !raced) begin
                    raced = 1;
                    snoopValid[d] = 1; snoopCommand[d] = 2'd3; snoopAddress[d] = a;
                    mSnoop(d, 3, a, expSh, expFl);
                    snoopChk = 1;
                end else if (grantWait == 0) busGrant[d] = 1;
                else grantWait--;
            end
            if (busCommand[d] != 0) begin
                if (gotCmd == 0) begin
                    gotCmd = int'(busCommand[d]);
                    chk("busAddr", busAddress[d], a);
                end
                if (busWait == 0) begin
                    busDone[d] = 1; busSharedIn[d] = sh; doneAt = cyc;
                end else busWait--;
            end
        end
        chk("cpuDone", cpuDone[d], 1);
        cpuRead[d] = 0; cpuWrite[d] = 0;
        chk("busCmd", gotCmd, expCmd);
        chk("writeBack", gotWB, expWB);
        if (expCmd == 0) chk("hitLatency", cyc, conflict ? 2 : 1);
        else chk("fillLatency", cyc - doneAt, 1);
        @(negedge clock);
        chk("donePulse", cpuDone[d], 0);
        if (expCmd != 0) begin
            mTag[d][idx]   = a[11:4];
            mState[d][idx] = wr ? 3 : ((mesi[d] && !sh) ? 2 : 1);
        end else if (wr) begin
            mState[d][idx] = 3;
        end
    endtask

    task automatic randomTraffic(input int d, input int n);
        logic [7:0]  tags[4] = '{8'h1A, 8'h2B, 8'h3C, 8'h10};
        logic [11:0] a, sA;
        for (int i = 0; i < n; i++) begin
            a  = {tags[$urandom_range(0, 3)], 4'($urandom_range(0, 3))};
            sA = {tags[$urandom_range(0, 3)], a[3:0]};
            case ($urandom_range(0, 5))
                0, 1:    cpuAccess(d, 1'b0, a, 1'($urandom), 0, '0, 1'b0);
                2, 3:    cpuAccess(d, 1'b1, a, 1'($urandom), 0, '0, 1'b0);
                4:       snoop(d, $urandom_range(1, 3), sA);
                default: cpuAccess(d, 1'($urandom), a, 1'($urandom),
                                   $urandom_range(1, 3), sA, 1'b0);
            endcase
        end
    endtask

    initial begin
        reset = 1'b0;
        for (int d = 0; d < 2; d++) begin
            cpuRead[d] = 0; cpuWrite[d] = 0; cpuAddress[d] = '0;
            writeBackDone[d] = 0; busGrant[d] = 0; busSharedIn[d] = 0; busDone[d] = 0;
            snoopValid[d] = 0; snoopCommand[d] = '0; snoopAddress[d] = '0;
        end
        clearModel();
        repeat (3) @(negedge clock);
        chk("resetOuts0", allOuts(0), 0);
        chk("resetOuts1", allOuts(1), 0);
        reset = 1'b1;

        // MESI: exclusive fill, silent upgrade
        cpuAccess(0, 1'b0, 12'h1A3, 1'b0, 0, '0, 1'b0);
        cpuAccess(0, 1'b1, 12'h1A3, 1'b0, 0, '0, 1'b0);
        // dirty victim write-back then read fill
        cpuAccess(0, 1'b1, 12'h2B5, 1'b0, 0, '0, 1'b0);
        cpuAccess(0, 1'b0, 12'h3C5, 1'b1, 0, '0, 1'b0);
        // snoop downgrade with flush, then invalidate without flush
        cpuAccess(0, 1'b1, 12'h107, 1'b0, 0, '0, 1'b0);
        snoop(0, 1, 12'h107);
        snoop(0, 2, 12'h107);
        snoop(0, 1, 12'h107);
        // upgrade race: INVALIDATE turns into READ_EXCLUSIVE
        cpuAccess(0, 1'b0, 12'h102, 1'b1, 0, '0, 1'b0);
        cpuAccess(0, 1'b1, 12'h102, 1'b0, 0, '0, 1'b1);
        cpuAccess(0, 1'b0, 12'h102, 1'b0, 0, '0, 1'b0);
        // same-index conflict: snoop kills the line the CPU wants
        cpuAccess(0, 1'b0, 12'h102, 1'b0, 2, 12'h102, 1'b0);
        randomTraffic(0, 150);

        // reset in the middle of a bus transaction
        cpuAccess(0, 1'b0, 12'h2B5, 1'b0, 0, '0, 1'b0);
        @(negedge clock);
        cpuRead[0] = 1; cpuAddress[0] = 12'hFFE;
        for (int i = 0; i < 20 && busCommand[0] == 0; i++) begin
            @(negedge clock);
            busGrant[0] = busRequest[0];
        end
        chk("rstInBusActive", busCommand[0], 1);
        reset = 1'b0;
        busGrant[0] = 0; cpuRead[0] = 0;
        #1;
        chk("rstAsyncOuts", allOuts(0), 0);
        chk("rstAsyncBusReq", busRequest[0], 0);
        clearModel();
        @(negedge clock);
        reset = 1'b1;
        cpuAccess(0, 1'b0, 12'h2B5, 1'b1, 0, '0, 1'b0);

        // MSI: read with no sharers fills SHARED, so write needs INVALIDATE
        cpuAccess(1, 1'b0, 12'h1A3, 1'b0, 0, '0, 1'b0);
        cpuAccess(1, 1'b1, 12'h1A3, 1'b0, 0, '0, 1'b0);
        cpuAccess(1, 1'b0, 12'h1A3, 1'b0, 0, '0, 1'b0);
        randomTraffic(1, 80);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule
